// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter (with dmem_arbiter_pkg)
// Brief   : Shares the data-memory bus between N_LD load FUs and the retired
//           store port; one tagged transaction in flight at a time.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        MEM_SIZE         size;
        BUS_COMMAND      command;
    } FU_MEM_PACKET;
endpackage

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int N_LD  = 2,
    parameter int TAG_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [N_LD-1:0]          ld_req,
    input  FU_MEM_PACKET [N_LD-1:0]  ld_packet,
    input  logic                     st_req,
    input  FU_MEM_PACKET             st_packet,
    output logic [N_LD-1:0]          ld_ack,
    output logic [XLEN-1:0]          load_data,
    output logic                     st_ack,
    output BUS_COMMAND               proc2Dmem_command,
    output logic [XLEN-1:0]          proc2Dmem_addr,
    output logic [XLEN-1:0]          proc2Dmem_data,
    output MEM_SIZE                  proc2Dmem_size,
    input  logic [TAG_W-1:0]         Dmem2proc_response,
    input  logic [XLEN-1:0]          Dmem2proc_data,
    input  logic [TAG_W-1:0]         Dmem2proc_tag
);

    localparam int c_own_w = (N_LD > 1) ? $clog2(N_LD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'h0,
        S_ISSUE = 2'h1,
        S_WAIT  = 2'h2,
        S_DRAIN = 2'h3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_own_w-1:0]  r_rr_ptr, w_rr_nxt;
    logic [c_own_w-1:0]  r_owner, w_owner_nxt;
    logic [c_own_w-1:0]  w_pick, w_owner_inc;
    logic                r_owner_is_st, w_owner_is_st_nxt;
    logic [XLEN-1:0]     r_addr, w_addr_nxt;
    logic [XLEN-1:0]     r_data, w_data_nxt;
    MEM_SIZE             r_size, w_size_nxt;
    logic [TAG_W-1:0]    r_tag, w_tag_nxt;
    logic                w_any_ld, w_accepted, w_tag_hit;
    int                  w_best;
    logic                w_unused;

    // Load data fields and packet command encodings carry no information here.
    assign w_unused    = ^{ld_packet, st_packet.command};
    assign load_data   = Dmem2proc_data;
    assign w_accepted  = |Dmem2proc_response;
    assign w_tag_hit   = (Dmem2proc_tag == r_tag);
    assign w_owner_inc = (r_owner == c_own_w'(N_LD - 1)) ? '0 : r_owner + 1'b1;

    // Round-robin pick: smallest rotational distance from rr_ptr wins.
    always_comb begin
        w_any_ld = 1'b0;
        w_pick   = '0;
        w_best   = N_LD;
        for (int i = 0; i < N_LD; i++) begin
            if (ld_req[i] && (((i - int'(r_rr_ptr) + N_LD) % N_LD) < w_best)) begin
                w_best   = (i - int'(r_rr_ptr) + N_LD) % N_LD;
                w_pick   = c_own_w'(i);
                w_any_ld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_nxt          = r_rr_ptr;
        w_owner_nxt       = r_owner;
        w_owner_is_st_nxt = r_owner_is_st;
        w_addr_nxt        = r_addr;
        w_data_nxt        = r_data;
        w_size_nxt        = r_size;
        w_tag_nxt         = r_tag;
        ld_ack            = '0;
        st_ack            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!squash) begin
                    if (st_req) begin
                        w_owner_is_st_nxt = 1'b1;
                        w_addr_nxt        = st_packet.addr;
                        w_data_nxt        = st_packet.data;
                        w_size_nxt        = st_packet.size;
                        w_state_nxt       = S_ISSUE;
                    end else if (w_any_ld) begin
                        w_owner_is_st_nxt = 1'b0;
                        w_owner_nxt       = w_pick;
                        w_addr_nxt        = ld_packet[w_pick].addr;
                        w_data_nxt        = '0;
                        w_size_nxt        = ld_packet[w_pick].size;
                        w_state_nxt       = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (r_owner_is_st) begin
                    if (w_accepted) begin
                        st_ack      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_accepted) begin
                    w_tag_nxt   = Dmem2proc_response;
                    w_state_nxt = squash ? S_DRAIN : S_WAIT;
                end else if (squash) begin
                    w_rr_nxt    = w_owner_inc;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_tag_hit) begin
                    ld_ack[r_owner] = !squash;
                    w_rr_nxt        = w_owner_inc;
                    w_state_nxt     = S_IDLE;
                end else if (squash) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_tag_hit) begin
                    w_rr_nxt    = w_owner_inc;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A reset cycle must not leak an ack from the abandoned transaction.
        if (reset) begin
            ld_ack = '0;
            st_ack = 1'b0;
        end
    end

    always_comb begin
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        proc2Dmem_size    = BYTE;
        if ((r_state == S_ISSUE) && !reset) begin
            proc2Dmem_command = r_owner_is_st ? BUS_STORE : BUS_LOAD;
            proc2Dmem_addr    = r_addr;
            proc2Dmem_data    = r_data;
            proc2Dmem_size    = r_size;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_owner_is_st <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_size        <= BYTE;
            r_tag         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_owner       <= w_owner_nxt;
            r_owner_is_st <= w_owner_is_st_nxt;
            r_addr        <= w_addr_nxt;
            r_data        <= w_data_nxt;
            r_size        <= w_size_nxt;
            r_tag         <= w_tag_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed cycle table plus randomized traffic against a
//           transaction-level reference model of the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int          N_LD   = 2;
    localparam logic [1:0]  C_N    = 2'd0;
    localparam logic [1:0]  C_L    = 2'd1;
    localparam logic [1:0]  C_S    = 2'd2;
    localparam logic [31:0] A0     = 32'h100;
    localparam logic [31:0] A1     = 32'h200;
    localparam logic [31:0] AS     = 32'h300;
    localparam logic [31:0] DS     = 32'hDEADBEEF;
    localparam logic [31:0] MEMVAL = 32'hCAFE0100;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    squash = 1'b0;
    logic [N_LD-1:0]         ld_req = '0;
    FU_MEM_PACKET [N_LD-1:0] ld_packet;
    logic                    st_req = 1'b0;
    FU_MEM_PACKET            st_packet;
    logic [N_LD-1:0]         ld_ack;
    logic [31:0]             load_data;
    logic                    st_ack;
    BUS_COMMAND              proc2Dmem_command;
    logic [31:0]             proc2Dmem_addr, proc2Dmem_data;
    MEM_SIZE                 proc2Dmem_size;
    logic [3:0]              Dmem2proc_response = '0;
    logic [31:0]             Dmem2proc_data = '0;
    logic [3:0]              Dmem2proc_tag = '0;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.N_LD(N_LD), .TAG_W(4)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .ld_req(ld_req), .ld_packet(ld_packet),
        .st_req(st_req), .st_packet(st_packet),
        .ld_ack(ld_ack), .load_data(load_data), .st_ack(st_ack),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
        .proc2Dmem_data(proc2Dmem_data), .proc2Dmem_size(proc2Dmem_size),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
        .Dmem2proc_tag(Dmem2proc_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, sq;
        logic [1:0]  ldr;
        logic        str;
        logic [3:0]  resp, tag;
        logic [1:0]  elda;
        logic        esta;
        logic [1:0]  ecmd;
        logic [31:0] eaddr, edata;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, input logic sq, input logic [1:0] ldr, input logic str,
                     input logic [3:0] resp, input logic [3:0] tag, input logic [1:0] elda,
                     input logic esta, input logic [1:0] ecmd, input logic [31:0] eaddr,
                     input logic [31:0] edata);
        vec_t r;
        r.rst = rst; r.sq = sq; r.ldr = ldr; r.str = str; r.resp = resp; r.tag = tag;
        r.elda = elda; r.esta = esta; r.ecmd = ecmd; r.eaddr = eaddr; r.edata = edata;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {ld_ack,st_ack,cmd,addr,data}=%h required %h", name, got, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: load_data=%h required %h", name, got, exp);
        end
    endtask

    // Reference model: the one transaction in flight, described by its progress flags.
    bit          m_busy, m_acc, m_dead, m_st;
    int          m_fu, m_ptr;
    logic [3:0]  m_tag;
    logic [31:0] m_addr, m_data;
    logic [1:0]  m_size;

    initial begin
        bit          issuing, found, pend_v, drop_st;
        logic [1:0]  drop_ld, e_ld;
        logic [3:0]  pend_tag, next_tag, t;
        int          pend_cnt, j;
        logic        e_st;
        logic [1:0]  e_cmd, e_size;
        logic [31:0] e_addr, e_data;

        ld_packet[0] = '{addr: A0, data: 32'h0, size: WORD, command: BUS_LOAD};
        ld_packet[1] = '{addr: A1, data: 32'h0, size: WORD, command: BUS_LOAD};
        st_packet    = '{addr: AS, data: DS, size: HALF, command: BUS_STORE};
        Dmem2proc_data = MEMVAL;

        // rst sq ldr str resp tag | ld_ack st_ack cmd addr data
        v(1,0,0,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 3,0, 0,0,C_L,A0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 0,3, 1,0,C_N,0,0);
        v(1,0,0,0, 0,0, 0,0,C_N,0,0);
        v(0,0,3,1, 0,0, 0,0,C_N,0,0);
        v(0,0,3,1, 1,0, 0,1,C_S,AS,DS);
        v(0,0,3,0, 0,0, 0,0,C_N,0,0);
        v(0,0,3,0, 2,0, 0,0,C_L,A0,0);
        v(0,0,3,0, 0,2, 1,0,C_N,0,0);
        v(0,0,2,0, 0,0, 0,0,C_N,0,0);
        v(0,0,2,0, 4,0, 0,0,C_L,A1,0);
        v(0,0,2,0, 0,4, 2,0,C_N,0,0);
        v(0,0,3,0, 0,0, 0,0,C_N,0,0);
        for (int k = 0; k < 4; k++) v(0,0,3,0, 0,0, 0,0,C_L,A0,0);
        v(0,0,3,0, 5,0, 0,0,C_L,A0,0);
        v(0,1,3,0, 0,0, 0,0,C_N,0,0);
        v(0,0,2,0, 0,0, 0,0,C_N,0,0);
        v(0,0,2,0, 0,0, 0,0,C_N,0,0);
        v(0,0,2,0, 0,5, 0,0,C_N,0,0);
        v(0,0,2,0, 0,0, 0,0,C_N,0,0);
        v(0,0,2,0, 6,0, 0,0,C_L,A1,0);
        v(0,0,2,0, 0,6, 2,0,C_N,0,0);
        v(0,0,0,1, 0,0, 0,0,C_N,0,0);
        v(0,1,0,1, 0,0, 0,0,C_S,AS,DS);
        v(0,1,0,1, 7,0, 0,1,C_S,AS,DS);
        v(0,0,0,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 8,0, 0,0,C_L,A0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(1,0,0,0, 0,0, 0,0,C_N,0,0);
        v(0,0,0,0, 0,8, 0,0,C_N,0,0);
        v(0,0,0,0, 0,8, 0,0,C_N,0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 9,0, 0,0,C_L,A0,0);
        v(0,0,1,0, 0,9, 1,0,C_N,0,0);
        v(0,1,2,0, 0,0, 0,0,C_N,0,0);
        v(0,0,2,0, 0,0, 0,0,C_N,0,0);
        v(0,1,2,0, 0,0, 0,0,C_L,A1,0);
        v(0,0,0,0, 0,0, 0,0,C_N,0,0);
        v(0,0,1,0, 0,0, 0,0,C_N,0,0);
        v(0,1,1,0,10,0, 0,0,C_L,A0,0);
        v(0,0,0,0, 0,10,0,0,C_N,0,0);
        v(0,0,0,0, 0,0, 0,0,C_N,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock); #1;
            reset = vecs[i].rst; squash = vecs[i].sq; ld_req = vecs[i].ldr; st_req = vecs[i].str;
            Dmem2proc_response = vecs[i].resp; Dmem2proc_tag = vecs[i].tag;
            #3;
            check($sformatf("vec%0d", i),
                  {ld_ack, st_ack, 2'(proc2Dmem_command), proc2Dmem_addr, proc2Dmem_data},
                  {vecs[i].elda, vecs[i].esta, vecs[i].ecmd, vecs[i].eaddr, vecs[i].edata});
            if (vecs[i].elda != 2'b00) check_data($sformatf("vec%0d_data", i), load_data, MEMVAL);
        end

        // Randomized traffic
        @(posedge clock); #1;
        reset = 1'b1; squash = 1'b0; ld_req = '0; st_req = 1'b0;
        Dmem2proc_response = '0; Dmem2proc_tag = '0;
        m_busy = 0; m_acc = 0; m_dead = 0; m_st = 0; m_fu = 0; m_ptr = 0; m_tag = '0;
        m_addr = '0; m_data = '0; m_size = '0;
        pend_v = 0; pend_cnt = 0; pend_tag = '0; next_tag = 4'd1;
        drop_ld = '0; drop_st = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clock); #1;
            reset  = ($urandom_range(0, 199) == 0);
            squash = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N_LD; i++) begin
                if (drop_ld[i]) ld_req[i] = 1'b0;
                else if (!ld_req[i] && $urandom_range(0, 3) == 0) begin
                    ld_req[i] = 1'b1;
                    ld_packet[i].addr = $urandom;
                    ld_packet[i].data = $urandom;
                    ld_packet[i].size = MEM_SIZE'($urandom_range(0, 2));
                end
            end
            if (drop_st) st_req = 1'b0;
            else if (!st_req && $urandom_range(0, 5) == 0) begin
                st_req = 1'b1;
                st_packet.addr = $urandom;
                st_packet.data = $urandom;
                st_packet.size = MEM_SIZE'($urandom_range(0, 2));
            end
            issuing = m_busy && !m_acc && !reset;
            Dmem2proc_response = (issuing && $urandom_range(0, 2) != 0) ? next_tag : 4'd0;
            Dmem2proc_data = $urandom;
            Dmem2proc_tag = '0;
            if (pend_v && pend_cnt == 0) begin
                Dmem2proc_tag = pend_tag;
                pend_v = 0;
            end else begin
                if (pend_v) pend_cnt--;
                if ($urandom_range(0, 7) == 0) begin
                    do t = 4'($urandom_range(1, 15)); while (t == pend_tag || t == m_tag);
                    Dmem2proc_tag = t;
                end
            end
            #3;

            e_cmd  = issuing ? (m_st ? C_S : C_L) : C_N;
            e_addr = issuing ? m_addr : 32'h0;
            e_data = issuing ? m_data : 32'h0;
            e_size = issuing ? m_size : 2'd0;
            e_st   = issuing && m_st && (Dmem2proc_response != 0);
            e_ld   = '0;
            if (!reset && m_busy && !m_st && m_acc && !m_dead && !squash && Dmem2proc_tag == m_tag)
                e_ld[m_fu] = 1'b1;
            check($sformatf("rand%0d", cyc),
                  {ld_ack, st_ack, 2'(proc2Dmem_command), proc2Dmem_addr, proc2Dmem_data},
                  {e_ld, e_st, e_cmd, e_addr, e_data});
            n_checks++;
            if (2'(proc2Dmem_size) !== e_size) begin
                n_errors++;
                $display("FAIL rand%0d_size: size=%0d required %0d", cyc, proc2Dmem_size, e_size);
            end
            if (e_ld != 0) check_data($sformatf("rand%0d_data", cyc), load_data, Dmem2proc_data);

            if (e_cmd == C_L && Dmem2proc_response != 0) begin
                pend_v = 1; pend_tag = Dmem2proc_response; pend_cnt = $urandom_range(0, 4);
            end
            if (Dmem2proc_response != 0) next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            drop_ld = e_ld | ((squash || reset) ? 2'b11 : 2'b00);
            drop_st = e_st || reset;

            if (reset) begin
                m_busy = 0; m_acc = 0; m_dead = 0; m_ptr = 0;
            end else if (!m_busy) begin
                if (!squash) begin
                    if (st_req) begin
                        m_busy = 1; m_acc = 0; m_dead = 0; m_st = 1;
                        m_addr = st_packet.addr; m_data = st_packet.data; m_size = 2'(st_packet.size);
                    end else begin
                        found = 0;
                        for (int k = 0; k < N_LD; k++) begin
                            j = (m_ptr + k) % N_LD;
                            if (!found && ld_req[j]) begin
                                found = 1; m_fu = j;
                                m_busy = 1; m_acc = 0; m_dead = 0; m_st = 0;
                                m_addr = ld_packet[j].addr; m_data = 32'h0;
                                m_size = 2'(ld_packet[j].size);
                            end
                        end
                    end
                end
            end else if (!m_acc) begin
                if (m_st) begin
                    if (Dmem2proc_response != 0) m_busy = 0;
                end else if (Dmem2proc_response != 0) begin
                    m_acc = 1; m_tag = Dmem2proc_response; m_dead = squash;
                end else if (squash) begin
                    m_busy = 0; m_ptr = (m_fu + 1) % N_LD;
                end
            end else begin
                if (Dmem2proc_tag == m_tag) begin
                    m_busy = 0; m_ptr = (m_fu + 1) % N_LD;
                end else if (squash) begin
                    m_dead = 1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
